// File: rtl/mem_access_unit.sv
// Memory access unit: turns CPU byte/half/word load/store requests into
// single word-aligned bus cycles. It checks alignment, replicates store data
// across byte lanes, extracts and extends load data, and aborts a bus cycle
// that is not acknowledged within TIMEOUT cycles.
//
// Handshake rules: a request is taken on a rising edge where req_valid=1
// and req_ready=1 (req_ready is high only in IDLE). resp_valid is a
// one-cycle pulse with no back-pressure. On the bus side, bus_req and the
// other bus_* outputs stay constant until bus_ack=1 is sampled, or until
// the timeout expires.
module mem_access_unit #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_len,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic [1:0]  resp_err,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata
);

   typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

   // Value the wait counter holds on the last cycle allowed without an ack.
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        write_q, write_d;
   logic [1:0]  len_q, len_d;
   logic        sgn_q, sgn_d;
   logic [1:0]  lo_q, lo_d;
   logic        bus_req_q, bus_req_d;
   logic        bus_we_q, bus_we_d;
   logic [31:0] bus_addr_q, bus_addr_d;
   logic [3:0]  bus_be_q, bus_be_d;
   logic [31:0] bus_wdata_q, bus_wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic [1:0]  err_q, err_d;

   logic        misaligned;
   logic [3:0]  be_req;
   logic [31:0] wdata_req;
   logic [31:0] lane_w;
   logic [15:0] half_w;
   logic [31:0] load_data;

   // Decode the incoming request: alignment check, byte enables, lane-replicated data.
   always_comb begin
      misaligned = 1'b0;
      be_req     = 4'b1111;
      wdata_req  = req_wdata;
      case (req_len)
         2'd0: begin
            be_req    = 4'b0001 << req_addr[1:0];
            wdata_req = {4{req_wdata[7:0]}};
         end
         2'd1: begin
            misaligned = req_addr[0];
            be_req     = req_addr[1] ? 4'b1100 : 4'b0011;
            wdata_req  = {2{req_wdata[15:0]}};
         end
         2'd2: begin
            misaligned = (req_addr[1:0] != 2'b00);
         end
         default: begin
            misaligned = 1'b1;
         end
      endcase
   end

   // Select the addressed lane of the returned word and extend it to 32 bits.
   always_comb begin
      lane_w = bus_rdata >> {lo_q, 3'b000};
      half_w = lo_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
      case (len_q)
         2'd0:    load_data = {{24{sgn_q & lane_w[7]}}, lane_w[7:0]};
         2'd1:    load_data = {{16{sgn_q & half_w[15]}}, half_w};
         default: load_data = bus_rdata;
      endcase
   end

   // Next-state logic for the IDLE -> ACCESS/RESP -> IDLE sequence.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      write_d     = write_q;
      len_d       = len_q;
      sgn_d       = sgn_q;
      lo_d        = lo_q;
      bus_req_d   = bus_req_q;
      bus_we_d    = bus_we_q;
      bus_addr_d  = bus_addr_q;
      bus_be_d    = bus_be_q;
      bus_wdata_d = bus_wdata_q;
      rdata_d     = rdata_q;
      err_d       = err_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               write_d = req_write;
               len_d   = req_len;
               sgn_d   = req_signed;
               lo_d    = req_addr[1:0];
               cnt_d   = 8'd0;
               if (misaligned) begin
                  state_d = RESP;
                  err_d   = req_write ? 2'd2 : 2'd1;
                  rdata_d = 32'd0;
               end else begin
                  state_d     = ACCESS;
                  bus_req_d   = 1'b1;
                  bus_we_d    = req_write;
                  bus_addr_d  = {req_addr[31:2], 2'b00};
                  bus_be_d    = be_req;
                  bus_wdata_d = wdata_req;
               end
            end
         end
         ACCESS: begin
            if (bus_ack || (cnt_q == TMO_LAST)) begin
               // An ack on the same edge as the timeout wins.
               state_d     = RESP;
               bus_req_d   = 1'b0;
               bus_we_d    = 1'b0;
               bus_addr_d  = 32'd0;
               bus_be_d    = 4'd0;
               bus_wdata_d = 32'd0;
               err_d       = bus_ack ? 2'd0 : 2'd3;
               rdata_d     = (bus_ack && !write_q) ? load_data : 32'd0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; reset drops any bus cycle immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= 8'd0;
         write_q     <= 1'b0;
         len_q       <= 2'd0;
         sgn_q       <= 1'b0;
         lo_q        <= 2'd0;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= 32'd0;
         bus_be_q    <= 4'd0;
         bus_wdata_q <= 32'd0;
         rdata_q     <= 32'd0;
         err_q       <= 2'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         write_q     <= write_d;
         len_q       <= len_d;
         sgn_q       <= sgn_d;
         lo_q        <= lo_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_addr_q  <= bus_addr_d;
         bus_be_q    <= bus_be_d;
         bus_wdata_q <= bus_wdata_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
      end
   end

   assign req_ready  = (state_q == IDLE);
   assign resp_valid = (state_q == RESP);
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;
   assign bus_req    = bus_req_q;
   assign bus_we     = bus_we_q;
   assign bus_addr   = bus_addr_q;
   assign bus_be     = bus_be_q;
   assign bus_wdata  = bus_wdata_q;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: bus-wait cycles before abort, range 1..255.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-004 SHALL have port req_valid  input  1  CPU access request.
REQ-005 SHALL have port req_ready  output  1  unit can accept a request.
REQ-006 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_len  input  2  access length: 0 byte, 1 half, 2 word, 3 reserved.
REQ-008 SHALL have port req_signed  input  1  load extension: 1 sign, 0 zero.
REQ-009 SHALL have port req_addr  input  32  byte address.
REQ-010 SHALL have port req_wdata  input  32  store data, right-justified.
REQ-011 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have port resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-013 SHALL have port resp_err  output  2  0 ok, 1 misaligned load/bad len, 2 misaligned store, 3 bus timeout.
REQ-014 SHALL have port bus_req  output  1  bus cycle active.
REQ-015 SHALL have port bus_we  output  1  bus write.
REQ-016 SHALL have port bus_addr  output  32  word address, bits [1:0] = 0.
REQ-017 SHALL have port bus_be  output  4  byte enables, bit n = byte lane n (bits 8n+7:8n).
REQ-018 SHALL have port bus_wdata  output  32  lane-replicated store data.
REQ-019 SHALL have port bus_ack  input  1  bus completion, sampled on clk.
REQ-020 SHALL have port bus_rdata  input  32  read data, valid when bus_ack=1.

Function
REQ-021 SHALL implement states IDLE, ACCESS, RESP; req_ready = 1 only in IDLE.
REQ-022 SHALL accept a request on an edge with state IDLE and req_valid=1, latching all req_* fields.
REQ-023 SHALL, on acceptance, go to RESP with resp_err 1 (load) or 2 (store) when len=3, len=1 with addr[0]=1, or len=2 with addr[1:0]!=0; no bus cycle issued.
REQ-024 SHALL otherwise go to ACCESS, driving registered bus_req=1, bus_addr={addr[31:2],2'b00}, bus_we=req_write.
REQ-025 SHALL set bus_be: byte 4'b0001<<addr[1:0]; half addr[1]?4'b1100:4'b0011; word 4'b1111 (loads and stores alike).
REQ-026 SHALL set bus_wdata: byte replicated x4, half replicated x2, word as-is.
REQ-027 SHALL hold all bus_* outputs stable in ACCESS until bus_ack=1 is sampled.
REQ-028 SHALL, on bus_ack=1 in ACCESS, deassert bus_req next cycle, go to RESP, resp_err=0.
REQ-029 SHALL, for loads, select lane by addr (byte: addr[1:0]; half: addr[1]) and extend to 32 bits per req_signed; word unchanged.
REQ-030 SHALL count ACCESS cycles without ack; when count reaches TIMEOUT, deassert bus_req, go to RESP with resp_err=3, resp_rdata=0.
REQ-031 SHALL give bus_ack priority over timeout on the same edge.
REQ-032 SHALL assert resp_valid for exactly the one RESP cycle, then return to IDLE; resp_rdata/resp_err held until next response.
REQ-033 SHALL ignore bus_ack outside ACCESS and req_valid outside IDLE.
REQ-034 Latency: accept edge T; bus_req high from T; ack sampled at T+1 earliest -> resp_valid in cycle after T+1; error path resp_valid in cycle after T.
REQ-035 Back-to-back: new request accepted in the IDLE cycle immediately following RESP.

Reset
REQ-036 SHALL, on rst_n=0, immediately force IDLE, clear timeout counter, drive req_ready=1 and all other outputs 0.
REQ-037 SHALL abandon any in-flight bus cycle on reset without response; bus_req drops asynchronously.

Verification
REQ-038 Load byte signed, addr 0x1003, bus_rdata 0x80AA5511, ack 1 cycle later -> bus_be 4'b1000, resp_rdata 0xFFFFFF80, resp_err 0.
REQ-039 Store half, addr 0x2002, wdata 0x0000BEEF -> bus_addr 0x2000, bus_be 4'b1100, bus_wdata 0xBEEFBEEF, bus_we 1, resp_err 0.
REQ-040 Load word addr 0x3001 -> no bus_req, resp_valid in cycle after accept, resp_err 1; store word same addr -> resp_err 2.
REQ-041 TIMEOUT=4, load word, no ack -> bus_req high 4 cycles, then resp_err 3, resp_rdata 0; ack on 4th cycle -> resp_err 0 instead.
REQ-042 Reset asserted mid-ACCESS -> bus_req 0 immediately, no resp_valid, req_ready 1; next request processed normally.
REQ-043 Load half unsigned addr 0x0002, bus_rdata 0x9234_0000, back-to-back second request -> resp_rdata 0x00009234, second accepted cycle after RESP.
